// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: scan FSM encoding, count width and default
// 640x480@60 raster constants used by the scan counter and the sync comparators.
package vga_timing_pkg;

    localparam int COUNT_W = 12;

    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_WIDTH = 96;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_WIDTH = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/vga_pixel_prescaler.sv
// Divides the system clock down to a one-clk pixel tick.
// The phase holds while enable is low so a paused scan resumes without losing a tick.
module vga_pixel_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic enable,
    input  logic clear,
    output logic pix_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] presc_q;
    logic [3:0] presc_d;

    // NOTE: default first so every path assigns presc_d and no latch is inferred.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (run && enable) begin
            presc_d = (presc_q == DIV_LAST) ? 4'd0 : presc_q + 4'd1;
        end
    end

    // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign pix_tick = run && enable && (presc_q == DIV_LAST);

endmodule

// File: rtl/vga_scan_counter.sv
// Raster scan counter: steps h/v position once per pixel tick and emits
// line-end, frame-end and active-video strobes for the pixel generator.
module vga_scan_counter
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               restart,
    output logic [COUNT_W-1:0] h_count,
    output logic [COUNT_W-1:0] v_count,
    output logic               pix_tick,
    output logic               line_end,
    output logic               frame_end,
    output logic               video_on
);

    if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_ACTIVE >= H_TOTAL ||
        V_ACTIVE >= V_TOTAL || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_params
        $error("vga_scan_counter: illegal timing parameters");
    end

    localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_ACT  = COUNT_W'(H_ACTIVE);
    localparam logic [COUNT_W-1:0] V_ACT  = COUNT_W'(V_ACTIVE);

    scan_state_e        state_q, state_d;
    logic [COUNT_W-1:0] h_q, h_d;
    logic [COUNT_W-1:0] v_q, v_d;
    logic               run;

    assign run = (state_q == ST_RUN);

    vga_pixel_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .enable   (enable),
        .clear    (restart),
        .pix_tick (pix_tick)
    );

    // restart outranks a coincident tick, so a wrapping tick cannot leak into the counts.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (restart) begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
        end else begin
            if (state_q == ST_IDLE && enable) begin
                state_d = ST_RUN;
            end
            if (pix_tick) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + COUNT_W'(1);
                end else begin
                    h_d = h_q + COUNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    assign h_count   = h_q;
    assign v_count   = v_q;
    assign line_end  = pix_tick && (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);
    assign video_on  = run && (h_q < H_ACT) && (v_q < V_ACT);

endmodule

// File: tb/tb_vga_scan_counter.sv
// Self-checking bench for vga_scan_counter on a reduced raster, compared every
// cycle against a tick-count model of the scan position.
module tb_vga_scan_counter;

    localparam int DIV  = 4;
    localparam int HT   = 20;
    localparam int VT   = 6;
    localparam int HA   = 16;
    localparam int VA   = 4;
    localparam int FRAME_CLKS = DIV * HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        restart;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic        pix_tick;
    logic        line_end;
    logic        frame_end;
    logic        video_on;

    int checks = 0;
    int errors = 0;

    // Model: the position is just the number of enabled RUN clocks divided down.
    bit     m_running;
    longint m_en_cycles;

    logic s_tick, s_line, s_frame;

    vga_scan_counter #(
        .CLK_DIV  (DIV),
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .restart   (restart),
        .h_count   (h_count),
        .v_count   (v_count),
        .pix_tick  (pix_tick),
        .line_end  (line_end),
        .frame_end (frame_end),
        .video_on  (video_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_h();
        return int'((m_en_cycles / DIV) % (HT * VT)) % HT;
    endfunction

    function automatic int m_v();
        return int'((m_en_cycles / DIV) % (HT * VT)) / HT;
    endfunction

    task automatic check_outputs();
        int  h, v;
        bit  tick, le, fe, von;
        h    = m_h();
        v    = m_v();
        tick = m_running && enable && ((m_en_cycles % DIV) == DIV - 1);
        le   = tick && (h == HT - 1);
        fe   = le && (v == VT - 1);
        von  = m_running && (h < HA) && (v < VA);
        check("h_count",   h_count,   12'(h));
        check("v_count",   v_count,   12'(v));
        check("pix_tick",  {11'd0, pix_tick},  {11'd0, tick});
        check("line_end",  {11'd0, line_end},  {11'd0, le});
        check("frame_end", {11'd0, frame_end}, {11'd0, fe});
        check("video_on",  {11'd0, video_on},  {11'd0, von});
        s_tick  = pix_tick;
        s_line  = line_end;
        s_frame = frame_end;
    endtask

    task automatic model_edge(input logic en, input logic rs);
        if (rs) begin
            m_running   = 1'b0;
            m_en_cycles = 0;
        end else if (!m_running) begin
            if (en) m_running = 1'b1;
        end else if (en) begin
            m_en_cycles++;
        end
    endtask

    task automatic step(input logic en, input logic rs);
        @(negedge clk);
        enable  = en;
        restart = rs;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(en, rs);
    endtask

    initial begin
        int n;
        int lines, frames;

        rst_n       = 1'b0;
        enable      = 1'b0;
        restart     = 1'b0;
        m_running   = 1'b0;
        m_en_cycles = 0;

        // Reset state while rst_n is held low.
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE with enable low stays frozen at the origin.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Enter RUN; the first tick lands on the DIV-th clk after entry.
        step(1'b1, 1'b0);
        n = 0;
        for (int i = 1; i <= 2 * DIV; i++) begin
            step(1'b1, 1'b0);
            if (s_tick) begin
                n = i;
                break;
            end
        end
        check("first_tick_latency", 12'(n), 12'(DIV));

        // Scan to h=10 then hold 37 clks with enable low.
        for (int i = 0; i < FRAME_CLKS && !(m_h() == 10 && (m_en_cycles % DIV) == 1); i++)
            step(1'b1, 1'b0);
        for (int i = 0; i < 37; i++) step(1'b0, 1'b0);
        check("hold_h", h_count, 12'd10);
        for (int i = 0; i < 3 * DIV; i++) step(1'b1, 1'b0);

        // One full frame of enabled clocks: VT line ends, exactly one frame end.
        lines  = 0;
        frames = 0;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            step(1'b1, 1'b0);
            lines  += int'(s_line);
            frames += int'(s_frame);
        end
        check("lines_per_frame",  12'(lines),  12'(VT));
        check("frames_per_frame", 12'(frames), 12'd1);

        // restart on the frame-wrapping tick.
        for (int i = 0; i < FRAME_CLKS && (m_en_cycles % FRAME_CLKS) != FRAME_CLKS - 1; i++)
            step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("restart_frame_strobe", {11'd0, s_frame}, 12'd1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 2 * DIV; i++) step(1'b1, 1'b0);

        // Asynchronous reset between edges at h=7, v=3.
        for (int i = 0; i < FRAME_CLKS && !(m_h() == 7 && m_v() == 3); i++)
            step(1'b1, 1'b0);
        @(negedge clk);
        enable  = 1'b1;
        restart = 1'b0;
        #1;
        rst_n = 1'b0;
        m_running   = 1'b0;
        m_en_cycles = 0;
        #1;
        check_outputs();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b1, 1'b0);
        for (int i = 0; i < 2 * DIV; i++) step(1'b1, 1'b0);

        // Randomized enable with rare restarts.
        for (int i = 0; i < 2500; i++)
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 199) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_counter.md
Name: vga_scan_counter

Overview:
- Upstream timing source for the VGA output path. Generates the 12-bit horizontal and vertical pixel/line counts that the horizontal and vertical sync comparators consume.
- Divides the system clock down to a pixel-rate tick and steps a raster position through a full frame.
- Emits line-end, frame-end and active-video strobes for the pixel generator.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (100 MHz -> 25 MHz); legal range 1..16
- H_TOTAL, 800, pixel ticks per line, including blanking; must be <= 4096
- V_TOTAL, 525, lines per frame; must be <= 4096
- H_ACTIVE, 640, visible pixels per line; must be < H_TOTAL
- V_ACTIVE, 480, visible lines per frame; must be < V_TOTAL

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run/hold control; sampled each clk
- restart  input  1  synchronous restart to raster origin; single-cycle pulse
- h_count  output  12  current pixel column, 0..H_TOTAL-1
- v_count  output  12  current line, 0..V_TOTAL-1
- pix_tick  output  1  one-clk strobe at pixel rate
- line_end  output  1  one-clk strobe on the tick that wraps h_count
- frame_end  output  1  one-clk strobe on the tick that wraps both counts
- video_on  output  1  high while the raster position is inside the active area and the block is running

Behaviour:
- Reset (rst_n low, asynchronous):
  - prescaler=0, h_count=0, v_count=0, state=IDLE.
  - pix_tick, line_end, frame_end and video_on are all 0.
- FSM states:
  - IDLE: counters frozen at 0; all strobes 0; video_on=0.
  - RUN: normal scanning.
- Transitions:
  - IDLE->RUN on the first clk with enable=1.
  - RUN->IDLE on restart=1.
  - enable=0 in RUN holds the current position (HOLD behaviour) and does not leave RUN.
- Prescaler:
  - In RUN with enable=1, counts 0..CLK_DIV-1 and wraps.
  - pix_tick = RUN && enable && prescaler==CLK_DIV-1. It is combinational from registers, so it asserts in the same cycle.
  - With CLK_DIV=1, pix_tick is high on every enabled RUN cycle.
- Counter stepping on pix_tick:
  - If h_count==H_TOTAL-1: h_count becomes 0 and v_count advances. v_count wraps to 0 if it was V_TOTAL-1, otherwise it increments.
  - Otherwise h_count increments.
- Strobes:
  - line_end = pix_tick && h_count==H_TOTAL-1.
  - frame_end = line_end && v_count==V_TOTAL-1.
  - Both are combinational, coincident with the wrapping tick, and exactly one clk wide.
- video_on = RUN && h_count<H_ACTIVE && v_count<V_ACTIVE. No pipeline delay relative to the counts.
- Latency:
  - Counts update on the clk edge that ends a pix_tick cycle.
  - From IDLE with enable held high, the first pix_tick comes CLK_DIV clks after the edge that enters RUN.
- enable deasserted mid-line:
  - prescaler, h_count and v_count all hold; no strobes.
  - On reassertion the scan resumes from the held prescaler value; no tick is lost or duplicated.
- restart:
  - Highest synchronous priority, also over a coincident pix_tick.
  - Next edge: prescaler, h_count and v_count = 0 and state=IDLE.
  - Rescanning starts from origin once enable is seen.
- Reset mid-frame: immediate asynchronous return to the reset values above, regardless of prescaler phase.
- Width: comparisons use 12-bit unsigned values; counts never exceed TOTAL-1, so there is no overflow.
- Parameter checks: an elaboration-time assertion rejects H_TOTAL or V_TOTAL > 4096, H_ACTIVE >= H_TOTAL, V_ACTIVE >= V_TOTAL, and CLK_DIV outside 1..16.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the FSM state encoding (IDLE, RUN);
  - the default timing constants (800/525/640/480, sync start/width values shared with the sync comparators);
  - COUNT_W=12.
- One natural sub-module, vga_pixel_prescaler: holds the CLK_DIV counter and produces pix_tick from enable and run.
- The h/v counters and the FSM stay in the top module.

Test Plan:
- Reset then enable=1, CLK_DIV=4 -> first pix_tick 4 clks after RUN entry. h_count steps 0,1,2 every 4 clks; video_on=1 from RUN entry.
- Run to h_count=799, v_count=0 -> line_end=1 for exactly one clk; next values h_count=0, v_count=1. video_on=0 for h_count 640..799.
- Run to h_count=799, v_count=524 -> line_end=1 and frame_end=1 together for one clk; next h_count=0, v_count=0. Total of 420000 pix_ticks per frame.
- At h_count=100, drop enable for 37 clks, then reassert -> h_count stays 100, no strobes while low. The next tick arrives after the remaining prescaler phase, giving exactly 4 enabled clks between ticks.
- restart coincident with pix_tick at h_count=799, v_count=524 -> no frame_end effect on counts. Next edge all counts 0, state IDLE, video_on=0; RUN resumes on enable.
- rst_n low for 1 ns between edges mid-frame (h_count=321, v_count=200) -> outputs go to 0 immediately, without waiting for clk. After release, with enable=1, the scan restarts at 0,0.
